// File: rtl/sparse_res_unloader.sv
// Result-RAM reader: after the multiplier's done pulse, walks the result RAM and
// streams N coefficients in index order. Optional macro RES_MOD_REDUCE_EN reduces each value mod Q.
module sparse_res_unloader #(
   parameter int N           = 1024,
   parameter int COEFF_WIDTH = 8,
   parameter int Q           = 251
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_mul_done,
   output logic                         o_ram_res_rd_en,
   output logic [$clog2(N/2)-1:0]       o_ram_res_rd_addr,
   input  logic [2*COEFF_WIDTH-1:0]     i_ram_res_data_out,
   output logic                         o_coeff_valid,
   output logic [COEFF_WIDTH-1:0]       o_coeff_data,
   output logic                         o_coeff_last,
   input  logic                         i_coeff_ready,
   output logic                         o_busy,
   output logic                         o_unload_done
);

   localparam int AW = $clog2(N/2);
   localparam int CW = COEFF_WIDTH;
   localparam logic [AW:0]   NWORDS    = (AW+1)'(N/2);
   localparam logic [AW-1:0] LAST_WORD = AW'(N/2-1);
`ifdef RES_MOD_REDUCE_EN
   localparam logic [CW-1:0] QL = CW'(Q);
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

   state_e            state_q, state_d;
   logic [AW:0]       rd_cnt_q, rd_cnt_d;
   logic              rd_pend_q;
   logic [2*CW-1:0]   fifo_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        fifo_cnt_q;
   logic              hsel_q;
   logic [AW-1:0]     word_idx_q;

   logic              rd_en, push, pop, hs, valid, last;
   logic [2*CW-1:0]   head;

   // Reduction is applied at capture so the output stays a pure register mux.
   function automatic logic [CW-1:0] reduce_f(input logic [CW-1:0] c);
`ifdef RES_MOD_REDUCE_EN
      if (c >= QL) return c - QL;
      return c;
`else
      return c;
`endif
   endfunction

   always_comb begin
      valid = (fifo_cnt_q != 2'd0);
      head  = fifo_q[rd_ptr_q];
      hs    = valid && i_coeff_ready;
      pop   = hs && hsel_q;
      push  = rd_pend_q;
      last  = valid && hsel_q && (word_idx_q == LAST_WORD);
      rd_en = (state_q == S_RUN)
              && ((fifo_cnt_q + {1'b0, rd_pend_q}) < 2'd2)
              && (rd_cnt_q < NWORDS);
   end

   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_mul_done) begin
               state_d  = S_RUN;
               rd_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (rd_en) rd_cnt_d = rd_cnt_q + (AW+1)'(1);
            if (hs && last) state_d = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_cnt_q   <= '0;
         rd_pend_q  <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= '0;
         hsel_q     <= 1'b0;
         word_idx_q <= '0;
         for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_pend_q <= rd_en;
         if (push) begin
            fifo_q[wr_ptr_q] <= {reduce_f(i_ram_res_data_out[2*CW-1:CW]),
                                 reduce_f(i_ram_res_data_out[CW-1:0])};
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q   <= ~rd_ptr_q;
            word_idx_q <= word_idx_q + AW'(1);
         end
         if (hs) hsel_q <= ~hsel_q;
         unique case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   assign o_ram_res_rd_en   = rd_en;
   assign o_ram_res_rd_addr = rd_cnt_q[AW-1:0];
   assign o_coeff_valid     = valid;
   assign o_coeff_data      = valid ? (hsel_q ? head[2*CW-1:CW] : head[CW-1:0]) : '0;
   assign o_coeff_last      = last;
   assign o_busy            = (state_q == S_RUN);
   assign o_unload_done     = (state_q == S_FIN);

endmodule

// File: tb/tb_sparse_res_unloader.sv
// Randomized bench for sparse_res_unloader: RAM model, expected coefficient queue
// derived from RAM contents, and per-cycle protocol/timing checks.
module tb_sparse_res_unloader;

   localparam int N  = 1024;
   localparam int CW = 8;
   localparam int AW = 9;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           i_mul_done = 1'b0;
   logic           o_ram_res_rd_en;
   logic [AW-1:0]  o_ram_res_rd_addr;
   logic [2*CW-1:0] i_ram_res_data_out = '0;
   logic           o_coeff_valid;
   logic [CW-1:0]  o_coeff_data;
   logic           o_coeff_last;
   logic           i_coeff_ready = 1'b0;
   logic           o_busy;
   logic           o_unload_done;

   sparse_res_unloader dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_mul_done         (i_mul_done),
      .o_ram_res_rd_en    (o_ram_res_rd_en),
      .o_ram_res_rd_addr  (o_ram_res_rd_addr),
      .i_ram_res_data_out (i_ram_res_data_out),
      .o_coeff_valid      (o_coeff_valid),
      .o_coeff_data       (o_coeff_data),
      .o_coeff_last       (o_coeff_last),
      .i_coeff_ready      (i_coeff_ready),
      .o_busy             (o_busy),
      .o_unload_done      (o_unload_done)
   );

   always #5 clk = ~clk;

   logic [2*CW-1:0] mem [N/2];

   always @(posedge clk)
      if (o_ram_res_rd_en) i_ram_res_data_out <= mem[o_ram_res_rd_addr];

   int n_cmp = 0;
   int n_bad = 0;
   int first_vals [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_coeff(input int c);
`ifdef RES_MOD_REDUCE_EN
      return (c >= 251) ? c - 251 : c;
`else
      return c;
`endif
   endfunction

   task automatic fill_pattern();
      for (int k = 0; k < N/2; k++)
         mem[k] = {8'((2*k+1) % 256), 8'((2*k) % 256)};
   endtask

   task automatic fill_random();
      for (int k = 0; k < N/2; k++) mem[k] = 16'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, o_coeff_valid, 0);
      check({tag, "_data"},  o_coeff_data, 0);
      check({tag, "_last"},  o_coeff_last, 0);
      check({tag, "_busy"},  o_busy, 0);
      check({tag, "_udone"}, o_unload_done, 0);
      check({tag, "_rden"},  o_ram_res_rd_en, 0);
      check({tag, "_addr"},  o_ram_res_rd_addr, 0);
   endtask

   // mode: 0 ready high, 1 ready alternating, 2 random ~30% stalls.
   // Called at a negedge with the DUT idle.
   task automatic run_unload(input int mode, input bit timing, input bit extra_done,
                             input int abort_at);
      int  exp_q [$];
      int  t, hs_cnt, issued, words_done, first_valid;
      bit  finished, prev_stall, prev_last, last_hs_prev, do_abort, aborted;
      logic [CW-1:0] prev_data;

      exp_q.delete();
      for (int k = 0; k < N/2; k++) begin
         exp_q.push_back(ref_coeff(int'(mem[k][CW-1:0])));
         exp_q.push_back(ref_coeff(int'(mem[k][2*CW-1:CW])));
      end
      t = -1; hs_cnt = 0; issued = 0; words_done = 0; first_valid = -1;
      finished = 0; prev_stall = 0; prev_last = 0; last_hs_prev = 0;
      do_abort = 0; aborted = 0; prev_data = '0;

      i_mul_done = 1'b1;
      for (int cyc = 0; cyc < 6000 && !finished && !aborted; cyc++) begin
         @(negedge clk);
         t++;
         i_mul_done = 1'b0;
         if (do_abort) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("abort");
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 20; j++) begin
               @(negedge clk);
               check("abort_no_udone", o_unload_done, 0);
               check("abort_idle_busy", o_busy, 0);
            end
            aborted = 1;
         end else begin
            case (mode)
               0:       i_coeff_ready = 1'b1;
               1:       i_coeff_ready = (t % 2 == 0);
               default: i_coeff_ready = ($urandom_range(0, 99) >= 30);
            endcase

            if (o_unload_done) begin
               check("udone_count", hs_cnt, N);
               check("udone_after_last", last_hs_prev, 1);
               check("udone_busy", o_busy, 0);
               if (timing) check("udone_time", t, N + 2);
               finished = 1;
            end else begin
               check("busy_run", o_busy, 1);
            end

            if (prev_stall) begin
               check("stall_valid", o_coeff_valid, 1);
               check("stall_data", o_coeff_data, prev_data);
               check("stall_last", o_coeff_last, prev_last);
            end

            if (o_ram_res_rd_en) begin
               check("rd_window", (issued - words_done) < 2, 1);
               check("rd_addr", o_ram_res_rd_addr, issued);
               check("rd_range", issued < N/2, 1);
               issued++;
            end

            if (timing && first_valid < 0 && o_coeff_valid) begin
               first_valid = t;
               check("first_valid_t", t, 2);
            end

            last_hs_prev = 0;
            if (o_coeff_valid && i_coeff_ready) begin
               if (hs_cnt < N) begin
                  check("data", o_coeff_data, exp_q[hs_cnt]);
                  check("last", o_coeff_last, hs_cnt == N - 1);
               end else begin
                  check("overrun", hs_cnt, N - 1);
               end
               if (hs_cnt < 4) first_vals[hs_cnt] = int'(o_coeff_data);
               last_hs_prev = (hs_cnt == N - 1);
               if (hs_cnt % 2 == 1) words_done++;
               if (extra_done && (hs_cnt == 10 || hs_cnt == N - 1)) i_mul_done = 1'b1;
               if (abort_at >= 0 && hs_cnt == abort_at) do_abort = 1;
               hs_cnt++;
            end
            prev_stall = o_coeff_valid && !i_coeff_ready;
            prev_data  = o_coeff_data;
            prev_last  = o_coeff_last;
         end
      end
      i_mul_done = 1'b0;

      if (!finished && !aborted) check("timeout", 0, 1);
      if (finished) begin
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("post_udone", o_unload_done, 0);
            check("post_busy", o_busy, 0);
            check("post_valid", o_coeff_valid, 0);
         end
      end
   endtask

   initial begin
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      fill_pattern();
      run_unload(0, 1'b1, 1'b0, -1);
      check("pattern_first", first_vals[0], 0);

      fill_random();
      run_unload(1, 1'b0, 1'b0, -1);

      fill_random();
      run_unload(2, 1'b0, 1'b1, -1);

      fill_pattern();
      run_unload(0, 1'b1, 1'b0, -1);
      check("restart_first", first_vals[0], 0);

      run_unload(2, 1'b0, 1'b0, 300);
      @(negedge clk);
      run_unload(0, 1'b1, 1'b0, -1);
      check("after_abort_first", first_vals[0], 0);

      fill_random();
      mem[0] = {8'd255, 8'd251};
      mem[1] = {8'd0, 8'd250};
      run_unload(0, 1'b1, 1'b0, -1);
`ifdef RES_MOD_REDUCE_EN
      check("mod_c0", first_vals[0], 0);
      check("mod_c1", first_vals[1], 4);
`else
      check("mod_c0", first_vals[0], 251);
      check("mod_c1", first_vals[1], 255);
`endif
      check("mod_c2", first_vals[2], 250);
      check("mod_c3", first_vals[3], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sparse_res_unloader.md
Name: sparse_res_unloader

Overview:
- Reader side of the sparse multiplier's result RAM (sparse_mul_* family).
- Waits for the multiplier's done pulse, then walks the result RAM from address 0 to N/2-1 with 1-cycle read latency.
- Unpacks each 2-coefficient word and streams the N coefficients in index order over a valid/ready interface.
- Replaces the software/testbench readout loop, so results can feed downstream hardware (encoder/compressor) directly.

Parameters:
- N, 1024, polynomial length (coefficient count); power of two.
- COEFF_WIDTH, 8, bits per coefficient.
- Q, 251, modulus; used only with RES_MOD_REDUCE_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_mul_done  in  1  single-cycle done pulse from the multiplier.
- o_ram_res_rd_en  out  1  result RAM read enable.
- o_ram_res_rd_addr  out  $clog2(N/2)  result RAM word address.
- i_ram_res_data_out  in  2*COEFF_WIDTH  RAM read data; [CW-1:0] is coeff 2k, [2CW-1:CW] is coeff 2k+1; valid the cycle after the read edge.
- o_coeff_valid  out  1  output coefficient valid.
- o_coeff_data  out  COEFF_WIDTH  coefficient value.
- o_coeff_last  out  1  high with coefficient N-1.
- i_coeff_ready  in  1  downstream ready.
- o_busy  out  1  high from done acceptance until unload complete.
- o_unload_done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; word buffer empty; in-flight read counter 0.
  - Asynchronous assertion at any time, including mid-stream.
  - Aborts the unload; no partial completion pulse.
- FSM IDLE -> RUN -> FIN -> IDLE.
  - IDLE: i_mul_done sampled high => RUN, read address counter = 0, o_busy = 1.
  - RUN: issues reads and streams coefficients; leaves when the handshake of coeff N-1 occurs.
  - FIN: one cycle; o_unload_done = 1, o_busy = 0; returns to IDLE.
- i_mul_done outside IDLE (RUN or FIN) is ignored.
- Read issue:
  - In RUN, o_ram_res_rd_en = 1 only when (words buffered + reads in flight) < 2 and the address counter has not passed N/2-1.
  - Address increments on each issued read; reads never wrap past N/2-1.
  - o_ram_res_rd_addr is a registered counter.
- Capture: a word read at edge E is captured into the 2-entry word FIFO at edge E+1.
- Unpack:
  - Head word yields the low half, then the high half.
  - Head word is popped after the high-half handshake.
  - Half-select toggles only on a handshake.
- Handshake:
  - Transfer when o_coeff_valid && i_coeff_ready.
  - While valid && !ready, o_coeff_data and o_coeff_last hold stable; valid is never withdrawn without a transfer.
- Output is registered and valid only when the FIFO is non-empty.
- o_coeff_last = 1 exactly on coefficient index N-1 (high half of word N/2-1).
- Latency:
  - Done sampled at edge E0: first read at E1, capture at E2, o_coeff_valid high after E2.
  - With ready held high: one coefficient per cycle with no bubbles.
  - o_unload_done pulses N+2 cycles after E0.
- Empty FIFO in RUN: o_coeff_valid = 0; reads continue per the issue rule.
- Full FIFO: no read issued.
- Simultaneous push and pop on the same edge is allowed; occupancy stays unchanged.

Optional Feature:
- Macro RES_MOD_REDUCE_EN.
- Defined: each output coefficient c in [0, 2^COEFF_WIDTH) is conditionally reduced combinationally before the output register: c >= Q => c - Q (single subtraction, valid because 2^CW < 2Q). Latency is unchanged.
- Undefined: raw RAM values are output unchanged; Q is unused.

Test Plan:
- RAM model word k = {(2k+1) mod 256, 2k mod 256}, ready held 1, done pulse:
  - 1024 coefficients, value i mod 256, in order.
  - last only on i = 1023.
  - first valid 2 cycles after done; unload_done 1026 cycles after done.
  - o_busy 1 throughout.
- Ready toggling 1,0,1,0 and random 30% stalls:
  - no drop or duplicate; data and last stable during stalls.
  - rd_en never exceeds 2 outstanding words.
  - address never exceeds 511.
- Second done pulses during RUN at coefficients 10 and 1023 -> ignored, single unload_done. A new done after unload_done -> restarts at address 0, value 0 first.
- rst_n low for 1 cycle after coefficient 300 handshake:
  - all outputs 0 immediately; no unload_done.
  - subsequent done -> full clean stream from 0.
- Word k = 0 preloaded {8'd255, 8'd251}:
  - RES_MOD_REDUCE_EN defined -> outputs 0, 4.
  - undefined -> outputs 251, 255.
  - values 250 and 0 pass unchanged in both builds.
